// File: rtl/mc_fsm_controller.sv
// Multicycle MIPS control FSM: FETCH/DECODE/EXE/MEM/WB/JUMP sequencing with a
// memory ready handshake, programmable memory timeout, trap state and a
// retired-instruction counter.
module mc_fsm_controller #(
    parameter int unsigned MEM_TIMEOUT = 16,
    parameter int unsigned CNT_W       = 32,
    parameter int unsigned TRAP_RESUME = 0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [5:0]       opcode,
    input  logic [5:0]       funct,
    input  logic             zero,
    input  logic             overflow,
    input  logic             mem_ready,
    output logic             pc_wr,
    output logic             ir_wr,
    output logic             reg_wr,
    output logic             mem_wr,
    output logic             mem_rd,
    output logic             alu_src,
    output logic [1:0]       reg_dst,
    output logic [1:0]       mem2reg,
    output logic             bac_op,
    output logic [1:0]       npc_sel,
    output logic [1:0]       ext_op,
    output logic [2:0]       alu_op,
    output logic [2:0]       state,
    output logic             trap,
    output logic [1:0]       trap_cause,
    output logic [CNT_W-1:0] retired
);

    typedef enum logic [2:0] {
        StFetch  = 3'd0,
        StDecode = 3'd1,
        StExe    = 3'd2,
        StMem    = 3'd3,
        StWb     = 3'd4,
        StJump   = 3'd5,
        StTrap   = 3'd6
    } state_e;

    typedef enum logic [4:0] {
        ClsIllegal, ClsAddu, ClsSubu, ClsSlt, ClsJr, ClsNop, ClsOri, ClsLw, ClsSw,
        ClsBeq, ClsLui, ClsJ, ClsAddi, ClsAddiu, ClsJal, ClsLb, ClsSb, ClsBltzal
    } cls_e;

    localparam int unsigned TmoW     = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT + 1) : 1;
    localparam int unsigned TmoLastI = (MEM_TIMEOUT == 0) ? 0 : MEM_TIMEOUT - 1;
    localparam logic [TmoW-1:0] TmoLast = TmoLastI[TmoW-1:0];
    localparam bit TmoEn = (MEM_TIMEOUT != 0);

    state_e            state_q, state_d;
    cls_e              cls_q, cls_d, cls_dec;
    logic [TmoW-1:0]   tmo_q, tmo_d;
    logic [1:0]        cause_q, cause_d;
    logic [CNT_W-1:0]  retired_q, retired_d;
    logic              tmo_hit;

    // Waiting cycle that would push the counter to MEM_TIMEOUT; mem_ready wins.
    assign tmo_hit = TmoEn && !mem_ready && (tmo_q == TmoLast);

    // Instruction class decode from the IR fields.
    always_comb begin
        cls_dec = ClsIllegal;
        case (opcode)
            6'h00: begin
                case (funct)
                    6'h21:   cls_dec = ClsAddu;
                    6'h23:   cls_dec = ClsSubu;
                    6'h2A:   cls_dec = ClsSlt;
                    6'h08:   cls_dec = ClsJr;
                    6'h00:   cls_dec = ClsNop;
                    default: cls_dec = ClsIllegal;
                endcase
            end
            6'h0D:   cls_dec = ClsOri;
            6'h23:   cls_dec = ClsLw;
            6'h2B:   cls_dec = ClsSw;
            6'h04:   cls_dec = ClsBeq;
            6'h0F:   cls_dec = ClsLui;
            6'h02:   cls_dec = ClsJ;
            6'h08:   cls_dec = ClsAddi;
            6'h09:   cls_dec = ClsAddiu;
            6'h03:   cls_dec = ClsJal;
            6'h20:   cls_dec = ClsLb;
            6'h28:   cls_dec = ClsSb;
            6'h01:   cls_dec = ClsBltzal;
            default: cls_dec = ClsIllegal;
        endcase
    end

    // State, latched class, timeout counter, trap cause and retire counter.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= StFetch;
            cls_q     <= ClsIllegal;
            tmo_q     <= '0;
            cause_q   <= 2'b00;
            retired_q <= '0;
        end else begin
            state_q   <= state_d;
            cls_q     <= cls_d;
            tmo_q     <= tmo_d;
            cause_q   <= cause_d;
            retired_q <= retired_d;
        end
    end

    // Next-state, trap cause, timeout and retire bookkeeping.
    always_comb begin
        state_d = state_q;
        cls_d   = cls_q;
        cause_d = cause_q;
        case (state_q)
            StFetch: begin
                if (mem_ready) begin
                    state_d = StDecode;
                end else if (tmo_hit) begin
                    state_d = StTrap;
                    cause_d = 2'b11;
                end
            end
            StDecode: begin
                cls_d = cls_dec;
                case (cls_dec)
                    ClsIllegal: begin
                        state_d = StTrap;
                        cause_d = 2'b01;
                    end
                    ClsJ, ClsJr: state_d = StJump;
                    ClsJal:      state_d = StWb;
                    ClsNop:      state_d = StFetch;
                    default:     state_d = StExe;
                endcase
            end
            StExe: begin
                case (cls_q)
                    ClsAddu, ClsSubu, ClsSlt, ClsOri, ClsLui, ClsAddiu: state_d = StWb;
                    ClsAddi: begin
                        if (overflow) begin
                            state_d = StTrap;
                            cause_d = 2'b10;
                        end else begin
                            state_d = StWb;
                        end
                    end
                    ClsLw, ClsLb, ClsSw, ClsSb: state_d = StMem;
                    ClsBeq:    state_d = zero ? StJump : StFetch;
                    ClsBltzal: state_d = zero ? StFetch : StWb;
                    default:   state_d = StFetch;
                endcase
            end
            StMem: begin
                if (mem_ready) begin
                    state_d = (cls_q == ClsLw || cls_q == ClsLb) ? StWb : StFetch;
                end else if (tmo_hit) begin
                    state_d = StTrap;
                    cause_d = 2'b11;
                end
            end
            StWb:    state_d = (cls_q == ClsJal || cls_q == ClsBltzal) ? StJump : StFetch;
            StJump:  state_d = StFetch;
            StTrap:  state_d = (TRAP_RESUME != 0) ? StFetch : StTrap;
            default: state_d = StFetch;
        endcase

        // Counter only runs while parked in FETCH/MEM; any state change clears it.
        tmo_d = '0;
        if (TmoEn && (state_q == StFetch || state_q == StMem) && state_d == state_q) begin
            tmo_d = tmo_q + 1'b1;
        end

        retired_d = retired_q;
        if (state_d == StFetch && state_q != StFetch && state_q != StTrap) begin
            retired_d = retired_q + CNT_W'(1);
        end
    end

    // Moore decode of datapath controls; all forced low while reset is high.
    always_comb begin
        pc_wr   = 1'b0;
        ir_wr   = 1'b0;
        reg_wr  = 1'b0;
        mem_wr  = 1'b0;
        mem_rd  = 1'b0;
        alu_src = 1'b0;
        reg_dst = 2'b00;
        mem2reg = 2'b00;
        bac_op  = 1'b0;
        npc_sel = 2'b00;
        ext_op  = 2'b00;
        alu_op  = 3'b000;
        if (!reset) begin
            case (state_q)
                StFetch: begin
                    mem_rd = 1'b1;
                    pc_wr  = mem_ready;
                    ir_wr  = mem_ready;
                end
                StExe: begin
                    case (cls_q)
                        ClsSubu, ClsBeq:   alu_op = 3'b001;
                        ClsSlt, ClsBltzal: alu_op = 3'b011;
                        ClsOri: begin
                            alu_src = 1'b1;
                            alu_op  = 3'b010;
                        end
                        ClsLui: begin
                            alu_src = 1'b1;
                            ext_op  = 2'b10;
                            alu_op  = 3'b010;
                        end
                        ClsAddiu, ClsAddi, ClsLw, ClsLb, ClsSw, ClsSb: begin
                            alu_src = 1'b1;
                            ext_op  = 2'b01;
                        end
                        default: alu_op = 3'b000;
                    endcase
                end
                StMem: begin
                    mem_rd = (cls_q == ClsLw || cls_q == ClsLb);
                    mem_wr = (cls_q == ClsSw || cls_q == ClsSb);
                    bac_op = (cls_q == ClsLb || cls_q == ClsSb);
                end
                StWb: begin
                    reg_wr = 1'b1;
                    case (cls_q)
                        ClsAddu, ClsSubu, ClsSlt: reg_dst = 2'b01;
                        ClsLw: mem2reg = 2'b01;
                        ClsLb: begin
                            mem2reg = 2'b01;
                            bac_op  = 1'b1;
                        end
                        ClsJal, ClsBltzal: begin
                            reg_dst = 2'b10;
                            mem2reg = 2'b10;
                        end
                        default: reg_dst = 2'b00;
                    endcase
                end
                StJump: begin
                    pc_wr = 1'b1;
                    case (cls_q)
                        ClsBeq, ClsBltzal: npc_sel = 2'b01;
                        ClsJ, ClsJal:      npc_sel = 2'b10;
                        ClsJr:             npc_sel = 2'b11;
                        default:           npc_sel = 2'b00;
                    endcase
                end
                default: pc_wr = 1'b0;
            endcase
        end
    end

    assign state      = state_q;
    assign trap       = (state_q == StTrap) && !reset;
    assign trap_cause = cause_q;
    assign retired    = retired_q;

endmodule

// File: tb/tb_mc_fsm_controller.sv
// Bench for mc_fsm_controller: per-cycle expected state/controls are queued as
// stimulus is driven and compared on the falling edge. A second instance with
// TRAP_RESUME=0 and a full-width counter shares the stimulus.
module tb_mc_fsm_controller;

    localparam logic [2:0] StFetch  = 3'd0;
    localparam logic [2:0] StDecode = 3'd1;
    localparam logic [2:0] StExe    = 3'd2;
    localparam logic [2:0] StMem    = 3'd3;
    localparam logic [2:0] StWb     = 3'd4;
    localparam logic [2:0] StJump   = 3'd5;
    localparam logic [2:0] StTrap   = 3'd6;

    logic        clk, reset;
    logic [5:0]  opcode, funct;
    logic        zero, overflow, mem_ready;

    logic        pc_wr, ir_wr, reg_wr, mem_wr, mem_rd, alu_src, bac_op, trap;
    logic [1:0]  reg_dst, mem2reg, npc_sel, ext_op, trap_cause;
    logic [2:0]  alu_op, state;
    logic [1:0]  retired;

    logic        h_pc_wr, h_ir_wr, h_reg_wr, h_mem_wr, h_mem_rd, h_alu_src, h_bac_op, h_trap;
    logic [1:0]  h_reg_dst, h_mem2reg, h_npc_sel, h_ext_op, h_trap_cause;
    logic [2:0]  h_alu_op, h_state;
    logic [31:0] h_retired;

    logic [18:0] obs;

    mc_fsm_controller #(.MEM_TIMEOUT(4), .CNT_W(2), .TRAP_RESUME(1)) dut (
        .clk(clk), .reset(reset), .opcode(opcode), .funct(funct), .zero(zero),
        .overflow(overflow), .mem_ready(mem_ready), .pc_wr(pc_wr), .ir_wr(ir_wr),
        .reg_wr(reg_wr), .mem_wr(mem_wr), .mem_rd(mem_rd), .alu_src(alu_src),
        .reg_dst(reg_dst), .mem2reg(mem2reg), .bac_op(bac_op), .npc_sel(npc_sel),
        .ext_op(ext_op), .alu_op(alu_op), .state(state), .trap(trap),
        .trap_cause(trap_cause), .retired(retired)
    );

    mc_fsm_controller #(.MEM_TIMEOUT(4), .CNT_W(32), .TRAP_RESUME(0)) dut_h (
        .clk(clk), .reset(reset), .opcode(opcode), .funct(funct), .zero(zero),
        .overflow(overflow), .mem_ready(mem_ready), .pc_wr(h_pc_wr), .ir_wr(h_ir_wr),
        .reg_wr(h_reg_wr), .mem_wr(h_mem_wr), .mem_rd(h_mem_rd), .alu_src(h_alu_src),
        .reg_dst(h_reg_dst), .mem2reg(h_mem2reg), .bac_op(h_bac_op), .npc_sel(h_npc_sel),
        .ext_op(h_ext_op), .alu_op(h_alu_op), .state(h_state), .trap(h_trap),
        .trap_cause(h_trap_cause), .retired(h_retired)
    );

    assign obs = {trap, pc_wr, ir_wr, reg_wr, mem_wr, mem_rd, alu_src, reg_dst, mem2reg,
                  bac_op, npc_sel, ext_op, alu_op};

    int n_checks = 0;
    int n_pass   = 0;
    int n_ret    = 0;

    string       tag_q[$];
    logic [2:0]  st_q[$];
    logic [18:0] ctl_q[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    function automatic logic [18:0] mk(input logic t, input logic pc, input logic ir,
                                       input logic rw, input logic mw, input logic mr,
                                       input logic src, input logic [1:0] dst,
                                       input logic [1:0] m2r, input logic bac,
                                       input logic [1:0] npc, input logic [1:0] ext,
                                       input logic [2:0] alu);
        return {t, pc, ir, rw, mw, mr, src, dst, m2r, bac, npc, ext, alu};
    endfunction

    function automatic logic [18:0] cf(input logic r);
        return mk(0, r, r, 0, 0, 1, 0, 2'b00, 2'b00, 0, 2'b00, 2'b00, 3'b000);
    endfunction
    function automatic logic [18:0] ce(input logic src, input logic [1:0] ext,
                                       input logic [2:0] alu);
        return mk(0, 0, 0, 0, 0, 0, src, 2'b00, 2'b00, 0, 2'b00, ext, alu);
    endfunction
    function automatic logic [18:0] cm(input logic rd, input logic wr, input logic bac);
        return mk(0, 0, 0, 0, wr, rd, 0, 2'b00, 2'b00, bac, 2'b00, 2'b00, 3'b000);
    endfunction
    function automatic logic [18:0] cw(input logic [1:0] dst, input logic [1:0] m2r,
                                       input logic bac);
        return mk(0, 0, 0, 1, 0, 0, 0, dst, m2r, bac, 2'b00, 2'b00, 3'b000);
    endfunction
    function automatic logic [18:0] cj(input logic [1:0] npc);
        return mk(0, 1, 0, 0, 0, 0, 0, 2'b00, 2'b00, 0, npc, 2'b00, 3'b000);
    endfunction

    localparam logic [18:0] CtlNone = 19'h00000;
    localparam logic [18:0] CtlTrap = 19'h40000;

    // Drive one cycle of inputs and queue the expected state/controls for it.
    task automatic cyc(input string tag, input logic mr, input logic z, input logic ov,
                       input logic [2:0] st, input logic [18:0] c);
        mem_ready = mr;
        zero      = z;
        overflow  = ov;
        tag_q.push_back(tag);
        st_q.push_back(st);
        ctl_q.push_back(c);
        @(posedge clk);
        #1;
    endtask

    task automatic chk_ret(input string tag);
        check({tag, ".retired"}, 32'(retired), 32'(n_ret % 4));
    endtask

    task automatic run_alu(input string tag, input logic [5:0] op, input logic [5:0] fn,
                           input logic src, input logic [1:0] ext, input logic [2:0] alu,
                           input logic [1:0] dst);
        opcode = op;
        funct  = fn;
        cyc({tag, "/F"}, 1, 0, 0, StFetch, cf(1));
        cyc({tag, "/D"}, 1, 0, 0, StDecode, CtlNone);
        cyc({tag, "/E"}, 1, 0, 0, StExe, ce(src, ext, alu));
        cyc({tag, "/W"}, 1, 0, 0, StWb, cw(dst, 2'b00, 0));
        n_ret++;
        chk_ret(tag);
    endtask

    task automatic run_ld(input string tag, input logic [5:0] op, input logic bac,
                          input int waits);
        opcode = op;
        funct  = 6'h00;
        cyc({tag, "/F"}, 1, 0, 0, StFetch, cf(1));
        cyc({tag, "/D"}, 1, 0, 0, StDecode, CtlNone);
        cyc({tag, "/E"}, 1, 0, 0, StExe, ce(1, 2'b01, 3'b000));
        for (int i = 0; i < waits; i++) cyc({tag, "/Mw"}, 0, 0, 0, StMem, cm(1, 0, bac));
        cyc({tag, "/M"}, 1, 0, 0, StMem, cm(1, 0, bac));
        cyc({tag, "/W"}, 1, 0, 0, StWb, cw(2'b00, 2'b01, bac));
        n_ret++;
        chk_ret(tag);
    endtask

    task automatic run_st(input string tag, input logic [5:0] op, input logic bac,
                          input int waits);
        opcode = op;
        funct  = 6'h00;
        cyc({tag, "/F"}, 1, 0, 0, StFetch, cf(1));
        cyc({tag, "/D"}, 1, 0, 0, StDecode, CtlNone);
        cyc({tag, "/E"}, 1, 0, 0, StExe, ce(1, 2'b01, 3'b000));
        for (int i = 0; i < waits; i++) cyc({tag, "/Mw"}, 0, 0, 0, StMem, cm(0, 1, bac));
        cyc({tag, "/M"}, 1, 0, 0, StMem, cm(0, 1, bac));
        n_ret++;
        chk_ret(tag);
    endtask

    // Scoreboard: compare the oldest queued expectation mid-cycle.
    always @(negedge clk) begin : mon
        string       t;
        logic [2:0]  s;
        logic [18:0] c;
        if (st_q.size() != 0) begin
            t = tag_q.pop_front();
            s = st_q.pop_front();
            c = ctl_q.pop_front();
            check({t, ".state"}, 32'(state), 32'(s));
            check({t, ".ctl"}, 32'(obs), 32'(c));
        end
    end

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        reset     = 1'b1;
        opcode    = 6'h00;
        funct     = 6'h00;
        zero      = 1'b0;
        overflow  = 1'b0;
        mem_ready = 1'b1;
        @(posedge clk);
        #1;
        check("rst.state", 32'(state), 32'(StFetch));
        check("rst.ctl", 32'(obs), 32'(CtlNone));
        check("rst.retired", 32'(retired), 32'd0);
        check("rst.cause", 32'(trap_cause), 32'd0);
        reset = 1'b0;

        // ALU, loads and stores
        run_alu("addu", 6'h00, 6'h21, 0, 2'b00, 3'b000, 2'b01);
        run_ld("lw3", 6'h23, 0, 3);
        check("lw3.trap", 32'(trap), 32'd0);
        run_ld("lb", 6'h20, 1, 0);
        run_st("sw", 6'h2B, 0, 0);
        run_st("sb1", 6'h28, 1, 1);
        run_alu("subu", 6'h00, 6'h23, 0, 2'b00, 3'b001, 2'b01);
        run_alu("slt", 6'h00, 6'h2A, 0, 2'b00, 3'b011, 2'b01);
        run_alu("ori", 6'h0D, 6'h3F, 1, 2'b00, 3'b010, 2'b00);
        run_alu("lui", 6'h0F, 6'h00, 1, 2'b10, 3'b010, 2'b00);
        run_alu("addiu", 6'h09, 6'h00, 1, 2'b01, 3'b000, 2'b00);
        run_alu("addi", 6'h08, 6'h00, 1, 2'b01, 3'b000, 2'b00);

        // NOP with two fetch wait states
        opcode = 6'h00;
        funct  = 6'h00;
        cyc("nopw/Fw", 0, 0, 0, StFetch, cf(0));
        cyc("nopw/Fw", 0, 0, 0, StFetch, cf(0));
        cyc("nopw/F", 1, 0, 0, StFetch, cf(1));
        cyc("nopw/D", 1, 0, 0, StDecode, CtlNone);
        n_ret++;
        chk_ret("nopw");

        // Branches and jumps
        opcode = 6'h04;
        cyc("beqt/F", 1, 0, 0, StFetch, cf(1));
        cyc("beqt/D", 1, 0, 0, StDecode, CtlNone);
        cyc("beqt/E", 1, 1, 0, StExe, ce(0, 2'b00, 3'b001));
        cyc("beqt/J", 1, 0, 0, StJump, cj(2'b01));
        n_ret++;
        cyc("beqn/F", 1, 0, 0, StFetch, cf(1));
        cyc("beqn/D", 1, 0, 0, StDecode, CtlNone);
        cyc("beqn/E", 1, 0, 0, StExe, ce(0, 2'b00, 3'b001));
        n_ret++;
        opcode = 6'h01;
        cyc("bltn/F", 1, 0, 0, StFetch, cf(1));
        cyc("bltn/D", 1, 0, 0, StDecode, CtlNone);
        cyc("bltn/E", 1, 1, 0, StExe, ce(0, 2'b00, 3'b011));
        n_ret++;
        cyc("bltt/F", 1, 0, 0, StFetch, cf(1));
        cyc("bltt/D", 1, 0, 0, StDecode, CtlNone);
        cyc("bltt/E", 1, 0, 0, StExe, ce(0, 2'b00, 3'b011));
        cyc("bltt/W", 1, 0, 0, StWb, cw(2'b10, 2'b10, 0));
        cyc("bltt/J", 1, 0, 0, StJump, cj(2'b01));
        n_ret++;
        opcode = 6'h02;
        cyc("j/F", 1, 0, 0, StFetch, cf(1));
        cyc("j/D", 1, 0, 0, StDecode, CtlNone);
        cyc("j/J", 1, 0, 0, StJump, cj(2'b10));
        n_ret++;
        opcode = 6'h03;
        cyc("jal/F", 1, 0, 0, StFetch, cf(1));
        cyc("jal/D", 1, 0, 0, StDecode, CtlNone);
        cyc("jal/W", 1, 0, 0, StWb, cw(2'b10, 2'b10, 0));
        cyc("jal/J", 1, 0, 0, StJump, cj(2'b10));
        n_ret++;
        opcode = 6'h00;
        funct  = 6'h08;
        cyc("jr/F", 1, 0, 0, StFetch, cf(1));
        cyc("jr/D", 1, 0, 0, StDecode, CtlNone);
        cyc("jr/J", 1, 0, 0, StJump, cj(2'b11));
        n_ret++;
        chk_ret("branches");

        // ADDI overflow: trap, no register write, resume instance returns to FETCH
        opcode = 6'h08;
        funct  = 6'h00;
        cyc("addiv/F", 1, 0, 0, StFetch, cf(1));
        cyc("addiv/D", 1, 0, 0, StDecode, CtlNone);
        cyc("addiv/E", 1, 0, 1, StExe, ce(1, 2'b01, 3'b000));
        cyc("addiv/T", 1, 0, 0, StTrap, CtlTrap);
        check("addiv.cause", 32'(trap_cause), 32'd2);
        check("addiv.state_after", 32'(state), 32'(StFetch));
        check("addiv.hold_state", 32'(h_state), 32'(StTrap));
        check("addiv.hold_trap", 32'(h_trap), 32'd1);
        check("addiv.hold_cause", 32'(h_trap_cause), 32'd2);
        chk_ret("addiv");

        // SW with mem_ready never asserted: timeout after four MEM cycles
        opcode = 6'h2B;
        cyc("swto/F", 1, 0, 0, StFetch, cf(1));
        cyc("swto/D", 1, 0, 0, StDecode, CtlNone);
        cyc("swto/E", 1, 0, 0, StExe, ce(1, 2'b01, 3'b000));
        for (int i = 0; i < 4; i++) cyc("swto/Mw", 0, 0, 0, StMem, cm(0, 1, 0));
        cyc("swto/T", 0, 0, 0, StTrap, CtlTrap);
        check("swto.cause", 32'(trap_cause), 32'd3);
        chk_ret("swto");

        // Illegal opcode
        opcode = 6'h3F;
        cyc("ill/F", 1, 0, 0, StFetch, cf(1));
        cyc("ill/D", 1, 0, 0, StDecode, CtlNone);
        cyc("ill/T", 1, 0, 0, StTrap, CtlTrap);
        check("ill.cause", 32'(trap_cause), 32'd1);
        chk_ret("ill");

        // Fetch timeout
        for (int i = 0; i < 4; i++) cyc("fto/Fw", 0, 0, 0, StFetch, cf(0));
        cyc("fto/T", 0, 0, 0, StTrap, CtlTrap);
        check("fto.cause", 32'(trap_cause), 32'd3);
        check("fto.hold_state", 32'(h_state), 32'(StTrap));
        chk_ret("fto");

        // Asynchronous reset while in MEM
        opcode = 6'h23;
        cyc("rstm/F", 1, 0, 0, StFetch, cf(1));
        cyc("rstm/D", 1, 0, 0, StDecode, CtlNone);
        cyc("rstm/E", 1, 0, 0, StExe, ce(1, 2'b01, 3'b000));
        mem_ready = 1'b0;
        #1;
        check("rstm.pre_state", 32'(state), 32'(StMem));
        #1;
        reset = 1'b1;
        #1;
        check("rstm.state", 32'(state), 32'(StFetch));
        check("rstm.ctl", 32'(obs), 32'(CtlNone));
        check("rstm.retired", 32'(retired), 32'd0);
        check("rstm.cause", 32'(trap_cause), 32'd0);
        check("rstm.hold_state", 32'(h_state), 32'(StFetch));
        @(posedge clk);
        #1;
        reset = 1'b0;
        n_ret = 0;

        // Five NOPs: 2-bit counter wraps to 1, full-width counter reads 5
        opcode = 6'h00;
        funct  = 6'h00;
        for (int i = 0; i < 5; i++) begin
            cyc("cnt/F", 1, 0, 0, StFetch, cf(1));
            cyc("cnt/D", 1, 0, 0, StDecode, CtlNone);
            n_ret++;
        end
        check("cnt.retired_w2", 32'(retired), 32'd1);
        check("cnt.retired_w32", h_retired, 32'(n_ret));
        check("end.queue_empty", 32'(st_q.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/mc_fsm_controller.md
# mc_fsm_controller

Parametrised multicycle control FSM for the MIPS datapath. It decodes opcode/funct and sequences FETCH, DECODE, EXE, MEM, WB and JUMP, driving all datapath write-enables and mux/op selects. It adds three things the fixed-latency controller lacks: a memory ready handshake with a programmable timeout, trap states in place of simulation halts, and a retired-instruction counter. It sits between the IR/ALU flag outputs and the datapath control inputs.

## Interface
- MEM_TIMEOUT, 16: cycles to wait for mem_ready in FETCH/MEM before a bus-error trap; 0 disables the timeout.
- CNT_W, 32: width of the retired-instruction counter.
- TRAP_RESUME, 0: 0 keeps the FSM in TRAP until reset; 1 makes TRAP last one cycle, then go to FETCH.
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- opcode  in  6  IR[31:26].
- funct  in  6  IR[5:0].
- zero  in  1  ALU zero flag, combinational, valid in EXE.
- overflow  in  1  ALU signed overflow, combinational, valid in EXE.
- mem_ready  in  1  memory completion strobe for FETCH and MEM.
- pc_wr, ir_wr, reg_wr, mem_wr, mem_rd  out  1 each  write/read enables.
- alu_src  out  1  0 = register B, 1 = extender output.
- reg_dst  out  2  00 rt, 01 rd, 10 r31.
- mem2reg  out  2  00 ALU, 01 memory, 10 PC (return address).
- bac_op  out  1  0 word, 1 byte.
- npc_sel  out  2  00 PC+4, 01 branch, 10 jump, 11 register.
- ext_op  out  2  00 zero-extend, 01 sign-extend, 10 LUI.
- alu_op  out  3  000 add, 001 sub, 010 or, 011 less-than.
- state  out  3  FETCH 0, DECODE 1, EXE 2, MEM 3, WB 4, JUMP 5, TRAP 6.
- trap  out  1  high while in TRAP.
- trap_cause  out  2  01 illegal instruction, 10 overflow, 11 memory timeout; sticky.
- retired  out  CNT_W  count of completed instructions.

## Operation
- Supported opcodes (hex):
  - SPECIAL 00 with funct ADDU 21, SUBU 23, SLT 2A, JR 08, NOP 00.
  - ORI 0D, LW 23, SW 2B, BEQ 04, LUI 0F, J 02, ADDI 08, ADDIU 09, JAL 03, LB 20, SB 28, BLTZAL 01.
- The instruction class is latched at the DECODE edge. Any other code sends DECODE to TRAP with cause 01.
- FETCH asserts mem_rd and npc_sel=00. pc_wr and ir_wr are high only in the cycle where mem_ready=1; the FSM then moves to DECODE.
- State sequences:
  - ADDU/SUBU/SLT: EXE(alu_src 0; add/sub/less) → WB(rd, ALU) → FETCH.
  - ORI/LUI/ADDIU: EXE(alu_src 1; ext zero/LUI/sign; or/or/add) → WB(rt) → FETCH.
  - ADDI: EXE(sign, add) → TRAP cause 10 if overflow, else WB(rt).
  - LW/LB: EXE(sign, add) → MEM(mem_rd, bac_op) → WB(rt, memory, bac_op held) → FETCH.
  - SW/SB: EXE → MEM(mem_wr, bac_op) → FETCH.
  - BEQ: EXE(sub) → JUMP(npc 01) if zero, else FETCH.
  - BLTZAL: EXE(less) → FETCH if zero, else WB(r31, PC) → JUMP(npc 01).
  - J: DECODE → JUMP(npc 10). JAL: DECODE → WB(r31, PC) → JUMP(npc 10). JR: DECODE → JUMP(npc 11). NOP: DECODE → FETCH.
- In MEM, mem_rd or mem_wr is held until mem_ready; the FSM leaves MEM on the cycle mem_ready=1.
- JUMP asserts pc_wr for one cycle.
- Timeout: a counter clears on entry to FETCH or MEM and increments each cycle without mem_ready. When it reaches MEM_TIMEOUT with mem_ready still low, the next state is TRAP with cause 11. mem_ready on that same cycle wins.
- Retired counter: increments by 1, wrapping modulo 2^CNT_W, on every transition into FETCH from DECODE, EXE, MEM, WB or JUMP. It never increments from TRAP.
- Unused select fields drive 0 in every state.

## Timing
- Reset:
  - state=FETCH, retired=0, trap_cause=00, timeout counter=0.
  - All outputs are forced to 0 while reset is high, including mem_rd.
  - Reset mid-instruction abandons the instruction with no further writes.
- All selects decode from the registered state (Moore). Exceptions are pc_wr/ir_wr in FETCH, which also depend on mem_ready (Mealy).
- Cycle counts with zero wait states (FETCH to next FETCH):
  - ALU instructions 4, loads 5, stores 4.
  - BEQ taken 4, not taken 3; J/JR 3; JAL 4; NOP 2.
  - Each extra cycle of mem_ready low adds one cycle.
- TRAP: trap=1 from the cycle after the trapping edge.
  - TRAP_RESUME=0: the FSM holds in TRAP.
  - TRAP_RESUME=1: after one TRAP cycle it goes to FETCH; PC is already advanced, so the faulting instruction is skipped.

## Test plan
- Reset, then ADDU with mem_ready tied 1: state sequence 0,1,2,4,0; reg_wr=1 with reg_dst=01 only in WB; retired=1.
- LW with mem_ready held low 3 cycles in MEM: mem_rd held for 4 MEM cycles; WB shows mem2reg=01; total 8 cycles; no trap.
- MEM_TIMEOUT=4, SW with mem_ready never asserted: TRAP entered after 4 MEM cycles; trap_cause=11; mem_wr drops; retired unchanged.
- ADDI with overflow=1 in EXE: TRAP with cause 10 and no reg_wr pulse. With TRAP_RESUME=1, FETCH follows one cycle later.
- BEQ with zero=1: JUMP with npc_sel=01, pc_wr=1. BEQ with zero=0: EXE goes directly to FETCH. BLTZAL with zero=0: WB(reg_dst=10, mem2reg=10) then JUMP.
- Opcode 3F: DECODE → TRAP with cause 01. Asserting reset in MEM returns state to 0 asynchronously with all outputs 0. CNT_W=2 and 5 instructions gives retired=1.
